// File: rtl/stash_scanner.sv
// Steps through a read-only stash one entry at a time, either on a debounced-free
// synchronized button edge or on a periodic auto-scan tick, and holds the last sample for display.
module stash_scanner #(
    parameter int unsigned DEPTH       = 32,
    parameter int unsigned TICK_PERIOD = 100000000,
    parameter int unsigned READ_LAT    = 1,
    localparam int unsigned IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             btn_next,
    input  logic             auto_en,
    input  logic [7:0]       stash_sample,
    output logic             next_sample,
    output logic [7:0]       shown_sample,
    output logic [IDX_W-1:0] shown_index,
    output logic             busy
);

    localparam int unsigned TICK_W = (TICK_PERIOD > 1) ? $clog2(TICK_PERIOD) : 1;
    localparam int unsigned LAT_W  = 4;

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_PERIOD - 1);
    localparam logic [LAT_W-1:0]  LAT_LAST  = LAT_W'(READ_LAT - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        PULSE,
        WAIT,
        CAPTURE
    } state_e;

    state_e            state_q, state_d;
    logic              btn_meta_q, btn_meta_d;
    logic              btn_sync_q, btn_sync_d;
    logic              btn_prev_q, btn_prev_d;
    logic [1:0]        sync_vld_q, sync_vld_d;
    logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
    logic              pending_q, pending_d;
    logic [LAT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic              next_sample_q, next_sample_d;
    logic              busy_q, busy_d;
    logic [7:0]        shown_sample_q, shown_sample_d;
    logic [IDX_W-1:0]  shown_index_q, shown_index_d;

    logic btn_rise_c;
    logic tick_req_c;
    logic step_req_c;

    // Request generation: synchronizer, edge detect and auto-scan tick.
    // btn_prev only tracks the synchronized level once the synchronizer holds real
    // samples, so a button held through reset must be seen low before it can step.
    always_comb begin
        btn_meta_d = btn_next;
        btn_sync_d = btn_meta_q;
        sync_vld_d = {sync_vld_q[0], 1'b1};
        btn_prev_d = sync_vld_q[1] ? btn_sync_q : btn_prev_q;
        btn_rise_c = sync_vld_q[1] & btn_sync_q & ~btn_prev_q;

        tick_req_c = auto_en && (tick_cnt_q == TICK_LAST);
        if (!auto_en || tick_cnt_q == TICK_LAST) begin
            tick_cnt_d = '0;
        end else begin
            tick_cnt_d = tick_cnt_q + TICK_W'(1);
        end

        step_req_c = btn_rise_c | tick_req_c;
    end

    // Step sequencer: next state, pending request and display registers
    always_comb begin
        state_d        = state_q;
        pending_d      = pending_q;
        wait_cnt_d     = wait_cnt_q;
        shown_sample_d = shown_sample_q;
        shown_index_d  = shown_index_q;

        if (state_q != IDLE && step_req_c) begin
            pending_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (step_req_c || pending_q) begin
                    state_d   = PULSE;
                    pending_d = 1'b0;
                end
            end
            PULSE: begin
                state_d    = WAIT;
                wait_cnt_d = '0;
            end
            WAIT: begin
                if (wait_cnt_q == LAT_LAST) begin
                    state_d = CAPTURE;
                end else begin
                    wait_cnt_d = wait_cnt_q + LAT_W'(1);
                end
            end
            CAPTURE: begin
                shown_sample_d = stash_sample;
                shown_index_d  = (shown_index_q == IDX_LAST) ? '0 : shown_index_q + IDX_W'(1);
                state_d        = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        next_sample_d = (state_d == PULSE);
        busy_d        = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            btn_meta_q     <= 1'b0;
            btn_sync_q     <= 1'b0;
            btn_prev_q     <= 1'b1;
            sync_vld_q     <= '0;
            tick_cnt_q     <= '0;
            pending_q      <= 1'b0;
            wait_cnt_q     <= '0;
            next_sample_q  <= 1'b0;
            busy_q         <= 1'b0;
            shown_sample_q <= '0;
            shown_index_q  <= '0;
        end else begin
            state_q        <= state_d;
            btn_meta_q     <= btn_meta_d;
            btn_sync_q     <= btn_sync_d;
            btn_prev_q     <= btn_prev_d;
            sync_vld_q     <= sync_vld_d;
            tick_cnt_q     <= tick_cnt_d;
            pending_q      <= pending_d;
            wait_cnt_q     <= wait_cnt_d;
            next_sample_q  <= next_sample_d;
            busy_q         <= busy_d;
            shown_sample_q <= shown_sample_d;
            shown_index_q  <= shown_index_d;
        end
    end

    assign next_sample  = next_sample_q;
    assign busy         = busy_q;
    assign shown_sample = shown_sample_q;
    assign shown_index  = shown_index_q;

endmodule

// File: tb/tb_stash_scanner.sv
// Scoreboard bench for stash_scanner: three instances cover short/long read latency,
// index wrap, auto-scan, request collisions, pending requests and reset.
module tb_stash_scanner;

    typedef struct packed {
        logic [7:0] s;
        logic [7:0] i;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]      rst;
    logic [2:0]      btn;
    logic [2:0]      aen;
    logic [2:0][7:0] stash;
    logic [2:0]      ns;
    logic [2:0]      bsy;
    logic [2:0][7:0] shown;
    logic [2:0][7:0] idx;
    logic [1:0]      idx0;
    logic [4:0]      idx1;
    logic [1:0]      idx2;

    assign idx[0] = 8'(idx0);
    assign idx[1] = 8'(idx1);
    assign idx[2] = 8'(idx2);

    // dut0: wrap/auto/collision, dut1: read latency 3, dut2: long busy window
    stash_scanner #(.DEPTH(4), .TICK_PERIOD(8), .READ_LAT(1)) u_dut0 (
        .clk(clk), .reset(rst[0]), .btn_next(btn[0]), .auto_en(aen[0]),
        .stash_sample(stash[0]), .next_sample(ns[0]), .shown_sample(shown[0]),
        .shown_index(idx0), .busy(bsy[0]));

    stash_scanner #(.DEPTH(32), .TICK_PERIOD(8), .READ_LAT(3)) u_dut1 (
        .clk(clk), .reset(rst[1]), .btn_next(btn[1]), .auto_en(aen[1]),
        .stash_sample(stash[1]), .next_sample(ns[1]), .shown_sample(shown[1]),
        .shown_index(idx1), .busy(bsy[1]));

    stash_scanner #(.DEPTH(4), .TICK_PERIOD(8), .READ_LAT(15)) u_dut2 (
        .clk(clk), .reset(rst[2]), .btn_next(btn[2]), .auto_en(aen[2]),
        .stash_sample(stash[2]), .next_sample(ns[2]), .shown_sample(shown[2]),
        .shown_index(idx2), .busy(bsy[2]));

    exp_t exp_q[3][$];
    int   checks = 0;
    int   errors = 0;
    int   pulse_cnt[3];
    int   cyc = 0;
    int   last_pulse;
    logic spacing_on;
    logic [2:0]      rst_edge = 3'b111;
    logic [2:0][7:0] last_idx;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_edge <= rst;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input int d, input logic [7:0] s, input logic [7:0] i);
        exp_t e;
        e.s = s;
        e.i = i;
        exp_q[d].push_back(e);
    endtask

    // Capture monitor: any index change not caused by reset is a capture to score
    task automatic monitor_cycle();
        exp_t e;
        for (int d = 0; d < 3; d++) begin
            if (!rst_edge[d] && idx[d] != last_idx[d]) begin
                if (exp_q[d].size() == 0) begin
                    chk($sformatf("unexpected_capture_dut%0d_idx", d), 32'(idx[d]), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q[d].pop_front();
                    chk($sformatf("capture_dut%0d_sample", d), 32'(shown[d]), 32'(e.s));
                    chk($sformatf("capture_dut%0d_index", d), 32'(idx[d]), 32'(e.i));
                end
            end
            last_idx[d] = idx[d];
            if (ns[d]) pulse_cnt[d]++;
        end
        if (ns[0] && spacing_on) begin
            if (last_pulse >= 0) chk("auto_pulse_spacing", 32'(cyc - last_pulse), 32'd8);
            last_pulse = cyc;
        end
    endtask

    initial begin
        rst        = 3'b111;
        btn        = '0;
        aen        = '0;
        stash      = '0;
        last_idx   = '0;
        spacing_on = 1'b0;
        last_pulse = -1;
        for (int d = 0; d < 3; d++) pulse_cnt[d] = 0;

        fork
            forever begin
                @(negedge clk);
                monitor_cycle();
            end
        join_none

        // reset values
        neg(3);
        chk("rst_next_sample", 32'(ns[0]), 32'd0);
        chk("rst_busy", 32'(bsy[0]), 32'd0);
        chk("rst_shown_sample", 32'(shown[0]), 32'd0);
        chk("rst_shown_index", 32'(idx[0]), 32'd0);
        rst = '0;
        neg(2);

        // manual step with cycle-exact latency (READ_LAT=1)
        stash[0] = 8'hA5;
        push(0, 8'hA5, 8'd1);
        btn[0] = 1'b1;
        neg(1); btn[0] = 1'b0;
        neg(1); chk("lat_ns_e1", 32'(ns[0]), 32'd0);
        neg(1); chk("lat_ns_e2", 32'(ns[0]), 32'd1);
        neg(1); chk("lat_ns_e3", 32'(ns[0]), 32'd0);
                chk("lat_busy_e3", 32'(bsy[0]), 32'd1);
        neg(1); chk("lat_shown_e4", 32'(shown[0]), 32'd0);
        neg(1); chk("lat_shown_e5", 32'(shown[0]), 32'hA5);
                chk("lat_index_e5", 32'(idx[0]), 32'd1);

        // four more steps: index 2,3,0,1
        for (int k = 0; k < 4; k++) begin
            neg(3);
            stash[0] = 8'h10 + 8'(k);
            push(0, 8'h10 + 8'(k), 8'((k + 2) % 4));
            btn[0] = 1'b1;
            neg(1); btn[0] = 1'b0;
            neg(8);
        end
        chk("wrap_pulses", 32'(pulse_cnt[0]), 32'd5);
        chk("wrap_index", 32'(idx[0]), 32'd1);

        // button held through reset must not step until released and pressed again
        btn[0] = 1'b1;
        rst[0] = 1'b1;
        neg(2); rst[0] = 1'b0;
        chk("held_rst_index", 32'(idx[0]), 32'd0);
        chk("held_rst_shown", 32'(shown[0]), 32'd0);
        neg(10);
        chk("held_no_pulse", 32'(pulse_cnt[0]), 32'd5);
        btn[0] = 1'b0;
        neg(3);
        stash[0] = 8'h77;
        push(0, 8'h77, 8'd1);
        btn[0] = 1'b1;
        neg(1); btn[0] = 1'b0;
        neg(8);
        chk("held_repress_pulse", 32'(pulse_cnt[0]), 32'd6);

        // auto scan: 40 cycles at period 8 -> 5 steps
        rst[0] = 1'b1;
        neg(2); rst[0] = 1'b0;
        aen[0] = 1'b1;
        stash[0] = 8'h3C;
        push(0, 8'h3C, 8'd1);
        push(0, 8'h3C, 8'd2);
        push(0, 8'h3C, 8'd3);
        push(0, 8'h3C, 8'd0);
        push(0, 8'h3C, 8'd1);
        spacing_on = 1'b1;
        last_pulse = -1;
        neg(40); aen[0] = 1'b0;
        neg(10);
        spacing_on = 1'b0;
        chk("auto_pulses", 32'(pulse_cnt[0]), 32'd11);
        chk("auto_index", 32'(idx[0]), 32'd1);

        // button edge and tick request land on the same edge -> one step
        rst[0] = 1'b1;
        neg(2); rst[0] = 1'b0;
        aen[0] = 1'b1;
        stash[0] = 8'hC3;
        push(0, 8'hC3, 8'd1);
        neg(5); btn[0] = 1'b1;
        neg(1); btn[0] = 1'b0;
        neg(2); aen[0] = 1'b0;
        neg(8);
        chk("collide_pulses", 32'(pulse_cnt[0]), 32'd12);
        chk("collide_index", 32'(idx[0]), 32'd1);

        // READ_LAT=3: stash changes 3 cycles after next_sample rises
        stash[1] = 8'h11;
        push(1, 8'hC7, 8'd1);
        btn[1] = 1'b1;
        neg(1); btn[1] = 1'b0;
        neg(2); chk("rl3_ns_e2", 32'(ns[1]), 32'd1);
        neg(3); stash[1] = 8'hC7;
        neg(1); chk("rl3_shown_e6", 32'(shown[1]), 32'd0);
        neg(1); chk("rl3_shown_e7", 32'(shown[1]), 32'hC7);
                chk("rl3_index_e7", 32'(idx[1]), 32'd1);

        // three requests while busy -> exactly one extra step
        stash[2] = 8'h5A;
        push(2, 8'h5A, 8'd1);
        push(2, 8'h5A, 8'd2);
        btn[2] = 1'b1;
        neg(1); btn[2] = 1'b0;
        for (int r = 0; r < 3; r++) begin
            neg(3); btn[2] = 1'b1;
            neg(1); btn[2] = 1'b0;
        end
        neg(40);
        chk("pend_pulses", 32'(pulse_cnt[2]), 32'd2);
        chk("pend_index", 32'(idx[2]), 32'd2);
        chk("pend_busy_end", 32'(bsy[2]), 32'd0);

        // reset during WAIT aborts the step
        btn[2] = 1'b1;
        neg(1); btn[2] = 1'b0;
        neg(5); chk("abort_busy_wait", 32'(bsy[2]), 32'd1);
        rst[2] = 1'b1;
        neg(1);
        chk("abort_ns", 32'(ns[2]), 32'd0);
        chk("abort_busy", 32'(bsy[2]), 32'd0);
        chk("abort_shown", 32'(shown[2]), 32'd0);
        chk("abort_index", 32'(idx[2]), 32'd0);
        rst[2] = 1'b0;
        neg(30);
        chk("abort_pulses", 32'(pulse_cnt[2]), 32'd3);
        chk("abort_index_after", 32'(idx[2]), 32'd0);

        for (int d = 0; d < 3; d++) begin
            chk($sformatf("queue_empty_dut%0d", d), 32'(exp_q[d].size()), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
